// File: rtl/axi_aw_router_if.sv
// AXI4 write-address bundle between one AXI master and NUM_SLAVES slave ports.
// The master-side fields are scalar, the slave-side fields are flat vectors
// where slice i belongs to slave i.
// Modport "slave" is the router view: it is the AXI slave of the master port
// and drives the per-slave request vectors.
// Modport "master" is the opposite view, used by whatever drives the router.
interface axi_aw_router_if #(
    parameter int ID_WIDTH   = 6,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SLAVES = 6
);
    // Master-side AW channel
    logic                           m_awvalid;
    logic                           m_awready;
    logic [ID_WIDTH-1:0]            m_awid;
    logic [ADDR_WIDTH-1:0]          m_awaddr;
    logic [7:0]                     m_awlen;
    logic [2:0]                     m_awsize;
    logic [1:0]                     m_awburst;
    logic [3:0]                     m_awcache;
    logic [1:0]                     m_awlock;
    logic [2:0]                     m_awprot;
    logic [3:0]                     m_awqos;
    logic [3:0]                     m_awregion;
    logic [0:0]                     m_awuser;

    // Slave-side AW channels, one slice per slave
    logic [NUM_SLAVES-1:0]          s_awvalid;
    logic [NUM_SLAVES-1:0]          s_awready;
    logic [NUM_SLAVES*ID_WIDTH-1:0] s_awid;
    logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_awaddr;
    logic [NUM_SLAVES*8-1:0]        s_awlen;
    logic [NUM_SLAVES*3-1:0]        s_awsize;
    logic [NUM_SLAVES*2-1:0]        s_awburst;
    logic [NUM_SLAVES*4-1:0]        s_awcache;
    logic [NUM_SLAVES*2-1:0]        s_awlock;
    logic [NUM_SLAVES*3-1:0]        s_awprot;
    logic [NUM_SLAVES*4-1:0]        s_awqos;
    logic [NUM_SLAVES*4-1:0]        s_awregion;
    logic [NUM_SLAVES-1:0]          s_awuser;

    modport slave (
        input  m_awvalid, m_awid, m_awaddr, m_awlen, m_awsize, m_awburst,
               m_awcache, m_awlock, m_awprot, m_awqos, m_awregion, m_awuser,
        output m_awready,
        output s_awvalid, s_awid, s_awaddr, s_awlen, s_awsize, s_awburst,
               s_awcache, s_awlock, s_awprot, s_awqos, s_awregion, s_awuser,
        input  s_awready
    );

    modport master (
        output m_awvalid, m_awid, m_awaddr, m_awlen, m_awsize, m_awburst,
               m_awcache, m_awlock, m_awprot, m_awqos, m_awregion, m_awuser,
        input  m_awready,
        input  s_awvalid, s_awid, s_awaddr, s_awlen, s_awsize, s_awburst,
               s_awcache, s_awlock, s_awprot, s_awqos, s_awregion, s_awuser,
        output s_awready
    );
endinterface

// File: rtl/axi_aw_router.sv
// AXI4 write-address router: one master, NUM_SLAVES targets.
// The incoming address is decoded against a region table (lowest matching
// region wins, last slave is the default target).
// The request is forwarded through a single registered output stage.
// Every accepted burst pushes its target index into an in-order route FIFO
// that steers the W channel mux; the mux pops it on the WLAST handshake.
//
// Optional feature macro AW_DECERR_EN:
//   defined   - unmapped addresses are accepted with sel = NUM_SLAVES, retired
//               one cycle after capture without touching any slave, and the
//               route FIFO gets index NUM_SLAVES so the W mux sinks the beats.
//               Adds the decerr_pulse / decerr_id outputs.
//   undefined - unmapped addresses go to slave NUM_SLAVES-1.
module axi_aw_router #(
    parameter int ID_WIDTH    = 6,
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_SLAVES  = 6,
    parameter logic [(NUM_SLAVES-1)*ADDR_WIDTH-1:0] REG_START =
        {32'h1A10_0000, 32'h0002_0000, 32'h0010_0000, 32'h0008_0000, 32'h0000_0000},
    parameter logic [(NUM_SLAVES-1)*ADDR_WIDTH-1:0] REG_END =
        {32'h1A12_0000, 32'h0002_1000, 32'h0010_8000, 32'h0008_0200, 32'h0000_8000},
    parameter int RFIFO_DEPTH = 4,
    localparam int IDX_W      = $clog2(NUM_SLAVES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    axi_aw_router_if.slave    bus,
    output logic              wroute_valid,
    output logic [IDX_W-1:0]  wroute_idx,
    input  logic              wroute_pop
`ifdef AW_DECERR_EN
    ,
    output logic              decerr_pulse,
    output logic [ID_WIDTH-1:0] decerr_id
`endif
);

    localparam int PTR_W = $clog2(RFIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

`ifdef AW_DECERR_EN
    localparam logic [IDX_W-1:0] MISS_IDX = IDX_W'(NUM_SLAVES);
`else
    localparam logic [IDX_W-1:0] MISS_IDX = IDX_W'(NUM_SLAVES - 1);
`endif

    // Region decode: lowest matching region index, MISS_IDX when nothing hits.
    function automatic logic [IDX_W-1:0] decode_region(input logic [ADDR_WIDTH-1:0] addr);
        logic [IDX_W-1:0] idx;
        logic             hit;
        idx = MISS_IDX;
        hit = 1'b0;
        for (int i = 0; i < NUM_SLAVES - 1; i++) begin
            if (!hit && (addr >= REG_START[i*ADDR_WIDTH +: ADDR_WIDTH])
                     && (addr <  REG_END[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                idx = IDX_W'(i);
                hit = 1'b1;
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Output stage registers
    logic                  ob_valid_r;
    logic [IDX_W-1:0]      ob_sel_r;
    logic [ID_WIDTH-1:0]   ob_id_r;
    logic [ADDR_WIDTH-1:0] ob_addr_r;
    logic [7:0]            ob_len_r;
    logic [2:0]            ob_size_r;
    logic [1:0]            ob_burst_r;
    logic [3:0]            ob_cache_r;
    logic [1:0]            ob_lock_r;
    logic [2:0]            ob_prot_r;
    logic [3:0]            ob_qos_r;
    logic [3:0]            ob_region_r;
    logic [0:0]            ob_user_r;

    // Route FIFO registers
    logic [IDX_W-1:0]      rfifo_mem_r [RFIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;

    // Combinational helpers
    logic [IDX_W-1:0]      decode_s;
    logic                  sel_ready_s;
    logic                  ob_miss_s;
    logic                  ob_hs_s;
    logic                  rfifo_full_s;
    logic                  pop_s;
    logic                  accept_ready_s;
    logic                  push_s;
    logic [NUM_SLAVES-1:0] slot_hit_s;

    assign decode_s = decode_region(bus.m_awaddr);

    // Ready of the currently selected slave; an out-of-range sel sees none.
    always_comb begin
        sel_ready_s = 1'b0;
        for (int j = 0; j < NUM_SLAVES; j++) begin
            sel_ready_s = sel_ready_s | ((ob_sel_r == IDX_W'(j)) & bus.s_awready[j]);
        end
    end

    // Output-stage handshake; a decode-error entry retires without a slave.
`ifdef AW_DECERR_EN
    assign ob_miss_s = (ob_sel_r == MISS_IDX);
`else
    assign ob_miss_s = 1'b0;
`endif
    assign ob_hs_s = ob_valid_r & (sel_ready_s | ob_miss_s);

    // Route FIFO status and accept logic; a same-cycle pop frees a full FIFO.
    assign rfifo_full_s   = (count_r == CNT_W'(RFIFO_DEPTH));
    assign pop_s          = wroute_pop & (count_r != {CNT_W{1'b0}});
    assign accept_ready_s = ~reset & (~ob_valid_r | ob_hs_s) & (~rfifo_full_s | pop_s);
    assign push_s         = bus.m_awvalid & accept_ready_s;
    assign bus.m_awready  = accept_ready_s;

    // Output stage: load on accept, retire on handshake, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            ob_valid_r  <= 1'b0;
            ob_sel_r    <= {IDX_W{1'b0}};
            ob_id_r     <= {ID_WIDTH{1'b0}};
            ob_addr_r   <= {ADDR_WIDTH{1'b0}};
            ob_len_r    <= 8'd0;
            ob_size_r   <= 3'd0;
            ob_burst_r  <= 2'd0;
            ob_cache_r  <= 4'd0;
            ob_lock_r   <= 2'd0;
            ob_prot_r   <= 3'd0;
            ob_qos_r    <= 4'd0;
            ob_region_r <= 4'd0;
            ob_user_r   <= 1'b0;
        end else if (push_s) begin
            ob_valid_r  <= 1'b1;
            ob_sel_r    <= decode_s;
            ob_id_r     <= bus.m_awid;
            ob_addr_r   <= bus.m_awaddr;
            ob_len_r    <= bus.m_awlen;
            ob_size_r   <= bus.m_awsize;
            ob_burst_r  <= bus.m_awburst;
            ob_cache_r  <= bus.m_awcache;
            ob_lock_r   <= bus.m_awlock;
            ob_prot_r   <= bus.m_awprot;
            ob_qos_r    <= bus.m_awqos;
            ob_region_r <= bus.m_awregion;
            ob_user_r   <= bus.m_awuser;
        end else if (ob_hs_s) begin
            ob_valid_r  <= 1'b0;
        end else begin
            ob_valid_r  <= ob_valid_r;
        end
    end

    // Route FIFO: push decoded target on accept, pop on W-mux request.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int k = 0; k < RFIFO_DEPTH; k++) begin
                rfifo_mem_r[k] <= {IDX_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                rfifo_mem_r[wr_ptr_r] <= decode_s;
                wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign wroute_valid = (count_r != {CNT_W{1'b0}});
    assign wroute_idx   = rfifo_mem_r[rd_ptr_r];

    // One-hot slave select from the registered stage.
    always_comb begin
        slot_hit_s = {NUM_SLAVES{1'b0}};
        for (int j = 0; j < NUM_SLAVES; j++) begin
            slot_hit_s[j] = ob_valid_r & (ob_sel_r == IDX_W'(j));
        end
    end

    // Per-slave payload fan-out; unselected slices are forced to zero.
    always_comb begin
        bus.s_awvalid  = slot_hit_s;
        bus.s_awid     = {NUM_SLAVES*ID_WIDTH{1'b0}};
        bus.s_awaddr   = {NUM_SLAVES*ADDR_WIDTH{1'b0}};
        bus.s_awlen    = {NUM_SLAVES*8{1'b0}};
        bus.s_awsize   = {NUM_SLAVES*3{1'b0}};
        bus.s_awburst  = {NUM_SLAVES*2{1'b0}};
        bus.s_awcache  = {NUM_SLAVES*4{1'b0}};
        bus.s_awlock   = {NUM_SLAVES*2{1'b0}};
        bus.s_awprot   = {NUM_SLAVES*3{1'b0}};
        bus.s_awqos    = {NUM_SLAVES*4{1'b0}};
        bus.s_awregion = {NUM_SLAVES*4{1'b0}};
        bus.s_awuser   = {NUM_SLAVES{1'b0}};
        for (int j = 0; j < NUM_SLAVES; j++) begin
            bus.s_awid[j*ID_WIDTH +: ID_WIDTH]       = ob_id_r     & {ID_WIDTH{slot_hit_s[j]}};
            bus.s_awaddr[j*ADDR_WIDTH +: ADDR_WIDTH] = ob_addr_r   & {ADDR_WIDTH{slot_hit_s[j]}};
            bus.s_awlen[j*8 +: 8]                    = ob_len_r    & {8{slot_hit_s[j]}};
            bus.s_awsize[j*3 +: 3]                   = ob_size_r   & {3{slot_hit_s[j]}};
            bus.s_awburst[j*2 +: 2]                  = ob_burst_r  & {2{slot_hit_s[j]}};
            bus.s_awcache[j*4 +: 4]                  = ob_cache_r  & {4{slot_hit_s[j]}};
            bus.s_awlock[j*2 +: 2]                   = ob_lock_r   & {2{slot_hit_s[j]}};
            bus.s_awprot[j*3 +: 3]                   = ob_prot_r   & {3{slot_hit_s[j]}};
            bus.s_awqos[j*4 +: 4]                    = ob_qos_r    & {4{slot_hit_s[j]}};
            bus.s_awregion[j*4 +: 4]                 = ob_region_r & {4{slot_hit_s[j]}};
            bus.s_awuser[j]                          = ob_user_r[0] & slot_hit_s[j];
        end
    end

`ifdef AW_DECERR_EN
    // Decode-error report while the unmapped entry sits in the output stage.
    assign decerr_pulse = ob_valid_r & ob_miss_s;
    assign decerr_id    = ob_id_r & {ID_WIDTH{ob_valid_r & ob_miss_s}};
`endif

endmodule

// File: tb/tb_axi_aw_router.sv
// Directed bench for axi_aw_router: decode table, stall, FIFO full, reset.
module tb_axi_aw_router;
    localparam int IDW = 6;
    localparam int AW  = 32;
    localparam int NS  = 6;
    localparam int IW  = 3;
`ifdef AW_DECERR_EN
    localparam int MISS = 6;
`else
    localparam int MISS = 5;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          wroute_valid;
    logic [IW-1:0] wroute_idx;
    logic          wroute_pop;
`ifdef AW_DECERR_EN
    logic           decerr_pulse;
    logic [IDW-1:0] decerr_id;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axi_aw_router_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .NUM_SLAVES(NS)) bus ();

    axi_aw_router #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .NUM_SLAVES(NS), .RFIFO_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .wroute_valid (wroute_valid),
        .wroute_idx   (wroute_idx),
        .wroute_pop   (wroute_pop)
`ifdef AW_DECERR_EN
        ,
        .decerr_pulse (decerr_pulse),
        .decerr_id    (decerr_id)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [5:0]  id;
        logic [7:0]  len;
        int          sel;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len);
        bus.m_awvalid  = 1'b1;
        bus.m_awaddr   = a;
        bus.m_awid     = id;
        bus.m_awlen    = len;
        bus.m_awsize   = 3'd2;
        bus.m_awburst  = 2'b01;
        bus.m_awcache  = 4'h3;
        bus.m_awlock   = 2'b00;
        bus.m_awprot   = 3'd0;
        bus.m_awqos    = 4'h0;
        bus.m_awregion = 4'h0;
        bus.m_awuser   = 1'b0;
    endtask

    task automatic drain(input int n, input int exp0, input int exp1, input int exp2, input int exp3);
        int exps [4];
        exps[0] = exp0; exps[1] = exp1; exps[2] = exp2; exps[3] = exp3;
        for (int k = 0; k < n; k++) begin
            check("drain_valid", 256'(wroute_valid), 256'(1'b1));
            check("drain_idx", 256'(wroute_idx), 256'(exps[k]));
            wroute_pop = 1'b1;
            @(posedge clk);
            @(negedge clk);
            wroute_pop = 1'b0;
        end
        check("drain_empty", 256'(wroute_valid), 256'(1'b0));
    endtask

    initial begin
        logic [255:0] e_addr, e_id, e_len;
        int a_sel [5];
        logic [31:0] a_addr [5];

        // Region layout: r0 [0,8000) r1 [80000,80200) r2 [100000,108000)
        // r3 [20000,21000) r4 [1A100000,1A120000); anything else is a miss.
        vecs[0]  = '{32'h0000_0100, 6'h01, 8'd3,  0};
        vecs[1]  = '{32'h0000_7FFF, 6'h02, 8'd0,  0};
        vecs[2]  = '{32'h0000_8000, 6'h03, 8'd1,  MISS};
        vecs[3]  = '{32'h0008_0000, 6'h04, 8'd15, 1};
        vecs[4]  = '{32'h0008_0200, 6'h05, 8'd2,  MISS};
        vecs[5]  = '{32'h0010_7FFC, 6'h06, 8'd7,  2};
        vecs[6]  = '{32'h1A11_FFFC, 6'h07, 8'd0,  4};
        vecs[7]  = '{32'h1A12_0000, 6'h08, 8'd1,  MISS};
        vecs[8]  = '{32'h0002_0FFF, 6'h09, 8'd4,  3};
        vecs[9]  = '{32'h0002_1000, 6'h0A, 8'd5,  MISS};
        vecs[10] = '{32'hF000_0000, 6'h2A, 8'd0,  MISS};
        vecs[11] = '{32'h0008_01FF, 6'h0B, 8'd9,  1};

        reset         = 1'b1;
        wroute_pop    = 1'b0;
        bus.s_awready = 6'b111111;
        drive(32'h0, 6'h0, 8'd0);
        bus.m_awvalid = 1'b0;

        // Reset behaviour
        @(negedge clk);
        check("rst_awready_low", 256'(bus.m_awready), 256'(1'b0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_awvalid", 256'(bus.s_awvalid), 256'(6'b0));
        check("rst_wroute_valid", 256'(wroute_valid), 256'(1'b0));
        check("rst_awready_high", 256'(bus.m_awready), 256'(1'b1));

        // Decode table
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            wroute_pop = 1'b0;
            drive(vecs[i].addr, vecs[i].id, vecs[i].len);
            #1;
            check("vec_awready", 256'(bus.m_awready), 256'(1'b1));
            @(posedge clk);
            @(negedge clk);
            bus.m_awvalid = 1'b0;
            e_addr = '0; e_id = '0; e_len = '0;
            if (vecs[i].sel < NS) begin
                e_addr[vecs[i].sel*AW +: AW] = vecs[i].addr;
                e_id[vecs[i].sel*IDW +: IDW] = vecs[i].id;
                e_len[vecs[i].sel*8 +: 8]    = vecs[i].len;
            end
            check("vec_awvalid", 256'(bus.s_awvalid),
                  (vecs[i].sel < NS) ? (256'(1) << vecs[i].sel) : 256'(0));
            check("vec_awaddr", 256'(bus.s_awaddr), e_addr);
            check("vec_awid", 256'(bus.s_awid), e_id);
            check("vec_awlen", 256'(bus.s_awlen), e_len);
            check("vec_wroute_valid", 256'(wroute_valid), 256'(1'b1));
            check("vec_wroute_idx", 256'(wroute_idx), 256'(vecs[i].sel));
`ifdef AW_DECERR_EN
            check("vec_decerr_pulse", 256'(decerr_pulse), 256'(vecs[i].sel == NS));
            check("vec_decerr_id", 256'(decerr_id),
                  (vecs[i].sel == NS) ? 256'(vecs[i].id) : 256'(0));
`endif
            wroute_pop = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("vec_popped", 256'(wroute_valid), 256'(1'b0));
            check("vec_retired", 256'(bus.s_awvalid), 256'(6'b0));
            @(posedge clk);
            @(negedge clk);
            check("vec_empty_pop_ignored", 256'(wroute_valid), 256'(1'b0));
            wroute_pop = 1'b0;
        end

        // Stall on slave 2: payload held, second request blocked
        @(negedge clk);
        bus.s_awready = 6'b111011;
        drive(32'h0010_0000, 6'h05, 8'd7);
        #1;
        check("stall_first_ready", 256'(bus.m_awready), 256'(1'b1));
        @(posedge clk);
        @(negedge clk);
        drive(32'h0000_0100, 6'h06, 8'd1);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("stall_awready", 256'(bus.m_awready), 256'(1'b0));
            check("stall_awvalid", 256'(bus.s_awvalid), 256'(6'b000100));
            check("stall_addr", 256'(bus.s_awaddr[2*AW +: AW]), 256'(32'h0010_0000));
            check("stall_id", 256'(bus.s_awid[2*IDW +: IDW]), 256'(6'h05));
            check("stall_len", 256'(bus.s_awlen[2*8 +: 8]), 256'(8'd7));
            @(posedge clk);
            @(negedge clk);
        end
        bus.s_awready = 6'b111111;
        #1;
        check("stall_release_ready", 256'(bus.m_awready), 256'(1'b1));
        @(posedge clk);
        @(negedge clk);
        bus.m_awvalid = 1'b0;
        check("stall_second_valid", 256'(bus.s_awvalid), 256'(6'b000001));
        check("stall_second_addr", 256'(bus.s_awaddr[0 +: AW]), 256'(32'h0000_0100));
        drain(2, 2, 0, 0, 0);

        // FIFO full: 4 back-to-back accepts, then push+pop at full
        a_addr[0] = 32'h0000_0100; a_sel[0] = 0;
        a_addr[1] = 32'h0008_0000; a_sel[1] = 1;
        a_addr[2] = 32'h0010_0000; a_sel[2] = 2;
        a_addr[3] = 32'h1A10_0000; a_sel[3] = 4;
        a_addr[4] = 32'h0002_0000; a_sel[4] = 3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(a_addr[k], 6'(k), 8'd0);
            #1;
            check("b2b_ready", 256'(bus.m_awready), 256'(1'b1));
            @(posedge clk);
        end
        @(negedge clk);
        drive(a_addr[4], 6'h04, 8'd0);
        #1;
        check("full_block", 256'(bus.m_awready), 256'(1'b0));
        check("full_head", 256'(wroute_idx), 256'(a_sel[0]));
        check("full_last_out", 256'(bus.s_awvalid), 256'(6'b010000));
        @(posedge clk);
        @(negedge clk);
        check("full_still_block", 256'(bus.m_awready), 256'(1'b0));
        wroute_pop = 1'b1;
        #1;
        check("full_pushpop_ready", 256'(bus.m_awready), 256'(1'b1));
        @(posedge clk);
        @(negedge clk);
        wroute_pop = 1'b0;
        bus.m_awvalid = 1'b0;
        #1;
        check("full_count_kept", 256'(bus.m_awready), 256'(1'b0));
        check("full_fifth_out", 256'(bus.s_awvalid), 256'(6'b001000));
        drain(4, a_sel[1], a_sel[2], a_sel[3], a_sel[4]);

        // Reset with a held request and three queued routes
        bus.s_awready = 6'b111110;
        @(negedge clk);
        drive(32'h0008_0000, 6'h11, 8'd0);
        @(posedge clk);
        @(negedge clk);
        drive(32'h0010_0000, 6'h12, 8'd0);
        @(posedge clk);
        @(negedge clk);
        drive(32'h0000_0100, 6'h13, 8'd0);
        @(posedge clk);
        @(negedge clk);
        bus.m_awvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("prerst_held", 256'(bus.s_awvalid), 256'(6'b000001));
        check("prerst_head", 256'(wroute_idx), 256'(3'd1));
        reset = 1'b1;
        #1;
        check("midrst_awready", 256'(bus.m_awready), 256'(1'b0));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.s_awready = 6'b111111;
        #1;
        check("postrst_awvalid", 256'(bus.s_awvalid), 256'(6'b0));
        check("postrst_wroute_valid", 256'(wroute_valid), 256'(1'b0));
        check("postrst_awready", 256'(bus.m_awready), 256'(1'b1));
        drive(32'h0000_0200, 6'h14, 8'd0);
        @(posedge clk);
        @(negedge clk);
        bus.m_awvalid = 1'b0;
        drain(1, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
